// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard FSM state and the hazard control bundle.
// Pure declarations; no logic, no latency.
// Control bundle constants encode the per-condition pipeline steering patterns.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hcu_state_t;

    typedef struct packed {
        logic       pcEn;
        logic [3:0] stageEn;
        logic [3:0] stageFlush;
    } hcu_ctrl_t;

    localparam hcu_ctrl_t CTRL_RUN       = '{pcEn: 1'b1, stageEn: 4'hF,    stageFlush: 4'h0};
    localparam hcu_ctrl_t CTRL_MEM_WAIT  = '{pcEn: 1'b0, stageEn: 4'h0,    stageFlush: 4'h0};
    localparam hcu_ctrl_t CTRL_LOAD_USE  = '{pcEn: 1'b0, stageEn: 4'b1110, stageFlush: 4'b0010};
    localparam hcu_ctrl_t CTRL_IMEM_WAIT = '{pcEn: 1'b0, stageEn: 4'hF,    stageFlush: 4'b0001};

    // Low FLUSH_DEPTH bits set: the younger registers squashed on a redirect.
    function automatic logic [3:0] flushMask(input int depth);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i < depth) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the hazard control unit and its environment.
// No logic; latency and backpressure are those of the unit itself.
// hcu modport is the unit's view, tb modport the driver's view.
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
) (
    input logic CLK
);
    import cpu_types_pkg::*;

    logic             RST;
    regbits_t         id_rs1;
    regbits_t         id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    regbits_t         ex_rd;
    logic             ex_memRead;
    logic             redirect;
    logic             dmem_wait;
    logic             imem_wait;
    logic             pc_en;
    logic [3:0]       stage_en;
    logic [3:0]       stage_flush;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hcu (
        input  CLK, RST, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memRead,
               redirect, dmem_wait, imem_wait,
        output pc_en, stage_en, stage_flush, freeze, stall_cnt, flush_cnt
    );

    modport tb (
        input  CLK, pc_en, stage_en, stage_flush, freeze, stall_cnt, flush_cnt,
        output RST, id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memRead,
               redirect, dmem_wait, imem_wait
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// One-cycle latency: count reflects inc sampled on the previous edge.
// No backpressure; inc is taken every cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard steering: PC/stage enables and bubbles for load-use, redirects and memory waits.
// Outputs are combinational from registered state and current inputs; counters lag one edge.
// dmem_wait freezes everything; a redirect seen during it is held and applied once memory is ready.
module hazard_control_unit
    import cpu_types_pkg::*;
#(
    parameter int FLUSH_DEPTH     = 3,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  regbits_t         id_rs1,
    input  regbits_t         id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  regbits_t         ex_rd,
    input  logic             ex_memRead,
    input  logic             redirect,
    input  logic             dmem_wait,
    input  logic             imem_wait,
    output logic             pc_en,
    output logic [3:0]       stage_en,
    output logic [3:0]       stage_flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0] FLUSH_MASK = flushMask(FLUSH_DEPTH);
    localparam logic [1:0] LU_EXTRA   = 2'(LOAD_USE_CYCLES - 1);

    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 4) begin : gBadFlushDepth
        $error("FLUSH_DEPTH must be 1..4");
    end
    if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 2) begin : gBadLoadUse
        $error("LOAD_USE_CYCLES must be 1..2");
    end

    hcu_state_t state, stateNext;
    logic       redirPending, redirPendingNext;
    logic [1:0] luCnt, luCntNext;
    logic       luHazard;
    logic       applyRedir;
    logic       luActive;
    hcu_ctrl_t  ctrl;

    assign luHazard = ex_memRead && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    assign applyRedir = !RST && !dmem_wait && (redirect || redirPending);

    // LU_STALL holds the bubble pattern without looking at the ID/EX operands again.
    assign luActive = (state == LU_STALL) || luHazard;

    always_comb begin
        ctrl = CTRL_RUN;
        if (RST) begin
            ctrl = CTRL_RUN;
        end else if (dmem_wait) begin
            ctrl = CTRL_MEM_WAIT;
        end else if (applyRedir) begin
            ctrl            = CTRL_RUN;
            ctrl.stageFlush = FLUSH_MASK;
        end else if (luActive) begin
            ctrl = CTRL_LOAD_USE;
        end else if (imem_wait) begin
            ctrl = CTRL_IMEM_WAIT;
        end
    end

    assign pc_en       = ctrl.pcEn;
    assign stage_en    = ctrl.stageEn;
    assign stage_flush = ctrl.stageFlush;
    assign freeze      = !ctrl.pcEn;

    always_comb begin
        stateNext        = state;
        redirPendingNext = redirPending;
        luCntNext        = luCnt;
        if (dmem_wait) begin
            // LU_STALL stays put with its count frozen until memory returns.
            redirPendingNext = redirPending || redirect;
            if (state == RUN) stateNext = MEM_WAIT;
        end else if (applyRedir) begin
            stateNext        = RUN;
            redirPendingNext = 1'b0;
            luCntNext        = '0;
        end else if (state == LU_STALL) begin
            if (luCnt <= 2'd1) begin
                stateNext = RUN;
                luCntNext = '0;
            end else begin
                luCntNext = luCnt - 2'd1;
            end
        end else if (luHazard && (LOAD_USE_CYCLES == 2)) begin
            stateNext = LU_STALL;
            luCntNext = LU_EXTRA;
        end else begin
            stateNext = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= RUN;
            redirPending <= 1'b0;
            luCnt        <= '0;
        end else begin
            state        <= stateNext;
            redirPending <= redirPendingNext;
            luCnt        <= luCntNext;
        end
    end

    sat_counter #(.W(CNT_W)) uStallCnt (
        .CLK (CLK),
        .RST (RST),
        .inc (!ctrl.pcEn),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .CLK (CLK),
        .RST (RST),
        .inc (applyRedir),
        .cnt (flush_cnt)
    );

endmodule
